controlador_estados: RTL and testbench

//  Top-level pet behaviour FSM. Drives the 5-bit `estado` bus that the attribute

---
 rtl/tamagotchi_defs.sv | 30 +++
 rtl/controlador_estados_if.sv | 41 ++++
 rtl/detector_borda.sv | 34 +++
 rtl/controlador_estados.sv | 111 +++++++++++
 tb/tb_controlador_estados.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tamagotchi_defs.sv
// -----------------------------------------------------------------------------
// tamagotchi_defs
// Definitions shared by the pet behaviour FSM, the attribute controller and
// the display: the one-hot-ish 5-bit estado encodings, attribute limits and
// the activity timer geometry.
// -----------------------------------------------------------------------------
package tamagotchi_defs;

  // INTRO is all-zero so a cleared register is a legal, safe state.
  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;

  localparam logic [7:0] MAX_ATRIBUTO  = 8'd100;
  localparam logic [7:0] LIMIAR_ALERTA = 8'd20;

  localparam int                      LARG_DURACAO   = 24;
  localparam logic [LARG_DURACAO-1:0] DURACAO_PADRAO = 24'd12_000_000;

  // True for the three timed activity states.
  function automatic logic em_atividade(estado_t e);
    return (e == DORMINDO) || (e == COMENDO) || (e == DANDO_AULA);
  endfunction

endpackage

// File: rtl/controlador_estados_if.sv
// -----------------------------------------------------------------------------
// controlador_estados_if
// Bundle between the button pins / attribute controller (master side) and the
// pet behaviour FSM (slave side).
//   btn_start/btn_dormir/btn_comer/btn_aula : raw buttons, asynchronous to clk
//   fome/felicidade/sono                    : attributes, 0..100, clk domain
//   estado                                  : current pet state encoding
//   mudou                                   : 1-cycle pulse after estado change
//   alerta                                  : some attribute is low
//   timer                                   : activity timer, for observation
// There is no valid/ready handshake on this bus: every signal is a level that
// is meaningful on every clk cycle, and the FSM never back-pressures.
// -----------------------------------------------------------------------------
interface controlador_estados_if;
  import tamagotchi_defs::*;

  logic                    btn_start;
  logic                    btn_dormir;
  logic                    btn_comer;
  logic                    btn_aula;
  logic [7:0]              fome;
  logic [7:0]              felicidade;
  logic [7:0]              sono;
  logic [4:0]              estado;
  logic                    mudou;
  logic                    alerta;
  logic [LARG_DURACAO-1:0] timer;

  modport master (
    output btn_start, btn_dormir, btn_comer, btn_aula,
    output fome, felicidade, sono,
    input  estado, mudou, alerta, timer
  );

  modport slave (
    input  btn_start, btn_dormir, btn_comer, btn_aula,
    input  fome, felicidade, sono,
    output estado, mudou, alerta, timer
  );

endinterface

// File: rtl/detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// Two-flop synchronizer for a raw button followed by a rising-edge detector.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw button level, asynchronous to clk
//   o_press    : 1-cycle pulse per synchronized rising edge
// Flops reset to 0, so releasing reset alone never looks like a press.
// -----------------------------------------------------------------------------
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/controlador_estados.sv
// -----------------------------------------------------------------------------
// controlador_estados
// Pet behaviour FSM. Turns button presses into activity states, ends an
// activity when its attribute is full, on timeout or on a repeat press of the
// same button, and enters MORTO when any attribute reaches 0.
//   clk, rst_n : clock, async active-low reset
//   bus        : controlador_estados_if.slave (buttons, attributes in;
//                estado, mudou, alerta, timer out)
// Parameter DURACAO: maximum number of clk cycles spent in one activity.
// -----------------------------------------------------------------------------
module controlador_estados
  import tamagotchi_defs::*;
#(
  parameter logic [LARG_DURACAO-1:0] DURACAO = DURACAO_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  controlador_estados_if.slave  bus
);

  localparam logic [LARG_DURACAO-1:0] UM = 1;

  estado_t                 r_estado;
  estado_t                 w_estado_next;
  logic [LARG_DURACAO-1:0] r_timer;
  logic [LARG_DURACAO-1:0] w_timer_next;
  logic                    r_mudou;
  logic                    r_alerta;

  logic w_press_start;
  logic w_press_dormir;
  logic w_press_comer;
  logic w_press_aula;
  logic w_morte;
  logic w_baixo;
  logic w_timeout;

  detector_borda u_det_start  (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_start),  .o_press(w_press_start));
  detector_borda u_det_dormir (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_dormir), .o_press(w_press_dormir));
  detector_borda u_det_comer  (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_comer),  .o_press(w_press_comer));
  detector_borda u_det_aula   (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_aula),   .o_press(w_press_aula));

  assign w_morte   = (bus.fome == 8'd0) || (bus.felicidade == 8'd0) || (bus.sono == 8'd0);
  assign w_baixo   = (bus.fome < LIMIAR_ALERTA) || (bus.felicidade < LIMIAR_ALERTA) ||
                     (bus.sono < LIMIAR_ALERTA);
  assign w_timeout = (r_timer == (DURACAO - UM));

  // Next state. Death is tested first in every live state so it outranks
  // presses and timeouts arriving in the same cycle.
  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      INTRO: begin
        if (w_press_start) w_estado_next = IDLE;
      end
      IDLE: begin
        if      (w_morte)        w_estado_next = MORTO;
        else if (w_press_dormir) w_estado_next = DORMINDO;
        else if (w_press_comer)  w_estado_next = COMENDO;
        else if (w_press_aula)   w_estado_next = DANDO_AULA;
      end
      DORMINDO: begin
        if (w_morte) w_estado_next = MORTO;
        else if ((bus.sono >= MAX_ATRIBUTO) || w_timeout || w_press_dormir) w_estado_next = IDLE;
      end
      COMENDO: begin
        if (w_morte) w_estado_next = MORTO;
        else if ((bus.fome >= MAX_ATRIBUTO) || w_timeout || w_press_comer) w_estado_next = IDLE;
      end
      DANDO_AULA: begin
        if (w_morte) w_estado_next = MORTO;
        else if ((bus.felicidade >= MAX_ATRIBUTO) || w_timeout || w_press_aula) w_estado_next = IDLE;
      end
      MORTO: begin
        if (w_press_start) w_estado_next = INTRO;
      end
      default: w_estado_next = INTRO;
    endcase
  end

  // Timer counts only while staying in the same activity; entering an
  // activity or being anywhere else leaves it at 0.
  always_comb begin
    w_timer_next = '0;
    if (em_atividade(w_estado_next) && (w_estado_next == r_estado)) begin
      w_timer_next = r_timer + UM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= INTRO;
      r_timer  <= '0;
      r_mudou  <= 1'b0;
      r_alerta <= 1'b0;
    end else begin
      r_estado <= w_estado_next;
      r_timer  <= w_timer_next;
      r_mudou  <= (w_estado_next != r_estado);
      // Judged against the state being entered so alerta is already 0 in
      // the first cycle of INTRO/MORTO.
      r_alerta <= w_baixo && (w_estado_next != INTRO) && (w_estado_next != MORTO);
    end
  end

  assign bus.estado = r_estado;
  assign bus.timer  = r_timer;
  assign bus.mudou  = r_mudou;
  assign bus.alerta = r_alerta;

endmodule

// File: tb/tb_controlador_estados.sv
module tb_controlador_estados;
  import tamagotchi_defs::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  controlador_estados_if bus ();

  controlador_estados #(.DURACAO(24'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // b = {start, dormir, comer, aula}
  task automatic set_btns(input logic [3:0] b);
    bus.btn_start  = b[3];
    bus.btn_dormir = b[2];
    bus.btn_comer  = b[1];
    bus.btn_aula   = b[0];
  endtask

  task automatic set_attr(input logic [7:0] f, input logic [7:0] fe, input logic [7:0] s);
    bus.fome       = f;
    bus.felicidade = fe;
    bus.sono       = s;
  endtask

  // One-cycle pulse on the pin; returns at the negedge after the edge where
  // the resulting state change lands (third edge after driving).
  task automatic press_btn(input logic [3:0] b);
    set_btns(b);
    step(1);
    set_btns(4'b0000);
    step(2);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [3:0] btn;
    logic [7:0] fome;
    logic [7:0] fel;
    logic [7:0] sono;
    logic [4:0] est;
    logic       mud;
    logic       ale;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] b, input logic [7:0] f, input logic [7:0] fe,
                     input logic [7:0] s, input logic [4:0] e, input logic m, input logic a);
    vec_t v;
    v.btn = b; v.fome = f; v.fel = fe; v.sono = s; v.est = e; v.mud = m; v.ale = a;
    vq.push_back(v);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    rst_n = 1'b0;
    set_btns(4'b0000);
    set_attr(8'd60, 8'd60, 8'd60);

    // reset state
    step(2);
    chk("reset_estado", 32'(bus.estado), 32'(INTRO));
    chk("reset_mudou",  32'(bus.mudou),  32'd0);
    chk("reset_alerta", 32'(bus.alerta), 32'd0);
    chk("reset_timer",  32'(bus.timer),  32'd0);
    rst_n = 1'b1;

    // idle in INTRO with no buttons
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("intro_hold_estado", 32'(bus.estado), 32'(INTRO));
      chk("intro_hold_mudou",  32'(bus.mudou),  32'd0);
    end

    // Each row: inputs driven at a negedge, outputs checked at the next negedge.
    // start held 5 cycles -> IDLE after 3 edges, single mudou
    add(4'b1000, 60, 60, 60, INTRO,      1'b0, 1'b0);
    add(4'b1000, 60, 60, 60, INTRO,      1'b0, 1'b0);
    add(4'b1000, 60, 60, 60, IDLE,       1'b1, 1'b0);
    add(4'b1000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b1000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    // dormir, then sono full ends the activity on the next edge
    add(4'b0100, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, DORMINDO,   1'b1, 1'b0);
    add(4'b0000, 60, 60, 100, IDLE,      1'b1, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    // three presses at once -> dormir wins; dormir again cancels
    add(4'b0111, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, DORMINDO,   1'b1, 1'b0);
    add(4'b0100, 60, 60, 60, DORMINDO,   1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, DORMINDO,   1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b1, 1'b0);
    // COMENDO: aula ignored, comer cancels
    add(4'b0010, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, COMENDO,    1'b1, 1'b0);
    add(4'b0001, 60, 60, 60, COMENDO,    1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, COMENDO,    1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, COMENDO,    1'b0, 1'b0);
    add(4'b0010, 60, 60, 60, COMENDO,    1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, COMENDO,    1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b1, 1'b0);
    // start ignored in IDLE
    add(4'b1000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    // alerta threshold
    add(4'b0000, 60, 19, 60, IDLE,       1'b0, 1'b1);
    add(4'b0000, 60, 20, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 19, 60, 60, IDLE,       1'b0, 1'b1);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    // DANDO_AULA ends when felicidade is full
    add(4'b0001, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, DANDO_AULA, 1'b1, 1'b0);
    add(4'b0000, 60, 100, 60, IDLE,      1'b1, 1'b0);
    add(4'b0000, 60, 60, 60, IDLE,       1'b0, 1'b0);
    // death from IDLE; MORTO ignores dormir, start -> INTRO
    add(4'b0000, 60, 60, 0,  MORTO,      1'b1, 1'b0);
    add(4'b0000, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b0100, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b1000, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, MORTO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, INTRO,      1'b1, 1'b0);
    // INTRO: no death check, activity buttons ignored
    add(4'b0000, 0,  60, 60, INTRO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, INTRO,      1'b0, 1'b0);
    add(4'b0010, 60, 60, 60, INTRO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, INTRO,      1'b0, 1'b0);
    add(4'b0000, 60, 60, 60, INTRO,      1'b0, 1'b0);

    foreach (vq[i]) begin
      set_btns(vq[i].btn);
      set_attr(vq[i].fome, vq[i].fel, vq[i].sono);
      step(1);
      chk($sformatf("vec%0d_estado", i), 32'(bus.estado), 32'(vq[i].est));
      chk($sformatf("vec%0d_mudou",  i), 32'(bus.mudou),  32'(vq[i].mud));
      chk($sformatf("vec%0d_alerta", i), 32'(bus.alerta), 32'(vq[i].ale));
    end

    // ---- timeout in DORMINDO: 16 cycles then IDLE
    press_btn(4'b1000);
    chk("to_idle", 32'(bus.estado), 32'(IDLE));
    press_btn(4'b0100);
    chk("to_dorm_estado", 32'(bus.estado), 32'(DORMINDO));
    chk("to_dorm_timer",  32'(bus.timer),  32'd0);
    for (int k = 1; k < 16; k++) begin
      step(1);
      chk($sformatf("to_dorm_k%0d_estado", k), 32'(bus.estado), 32'(DORMINDO));
      chk($sformatf("to_dorm_k%0d_timer",  k), 32'(bus.timer),  32'(k));
    end
    step(1);
    chk("to_exit_estado", 32'(bus.estado), 32'(IDLE));
    chk("to_exit_mudou",  32'(bus.mudou),  32'd1);
    chk("to_exit_timer",  32'(bus.timer),  32'd0);

    // ---- death beats timeout and cancel landing on the same edge
    press_btn(4'b0001);
    chk("dc_aula_estado", 32'(bus.estado), 32'(DANDO_AULA));
    step(13);
    chk("dc_timer13", 32'(bus.timer), 32'd13);
    set_btns(4'b0001);            // press lands on the timer==15 edge
    step(1);
    set_btns(4'b0000);
    step(1);
    chk("dc_timer15", 32'(bus.timer), 32'd15);
    set_attr(8'd0, 8'd60, 8'd60);
    step(1);
    chk("dc_morto_estado", 32'(bus.estado), 32'(MORTO));
    chk("dc_morto_mudou",  32'(bus.mudou),  32'd1);
    chk("dc_morto_alerta", 32'(bus.alerta), 32'd0);
    chk("dc_morto_timer",  32'(bus.timer),  32'd0);
    step(2);
    chk("dc_morto_hold", 32'(bus.estado), 32'(MORTO));
    press_btn(4'b1000);
    chk("dc_intro_estado", 32'(bus.estado), 32'(INTRO));
    chk("dc_intro_alerta", 32'(bus.alerta), 32'd0);
    set_attr(8'd60, 8'd60, 8'd60);

    // ---- async reset in the middle of COMENDO
    press_btn(4'b1000);
    chk("ar_idle", 32'(bus.estado), 32'(IDLE));
    press_btn(4'b0010);
    step(3);
    chk("ar_com_estado", 32'(bus.estado), 32'(COMENDO));
    chk("ar_com_timer",  32'(bus.timer),  32'd3);
    set_btns(4'b1000);            // pending start press, to be lost
    step(1);
    set_btns(4'b0000);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_async_estado", 32'(bus.estado), 32'(INTRO));
    chk("ar_async_timer",  32'(bus.timer),  32'd0);
    chk("ar_async_mudou",  32'(bus.mudou),  32'd0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("ar_post_estado", 32'(bus.estado), 32'(INTRO));
      chk("ar_post_mudou",  32'(bus.mudou),  32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
